vga_timing_scheduler: RTL and testbench

//  Generates 800x600@72Hz VGA timing on vga_clk (50 MHz) and schedules front-buffer page flips.

---
 rtl/vga_timing_scheduler_pkg.sv | 34 +++
 rtl/vga_timing_scheduler_toggle_sync.sv | 29 ++
 rtl/vga_timing_scheduler.sv | 154 +++++++++++++++
 tb/tb_vga_timing_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_scheduler_pkg.sv
// +---------------------------------------------------------------------------+
// | vga_timing_scheduler_pkg : 800x600@72 timing defaults, flip FSM states     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package vga_timing_scheduler_pkg;

    localparam int DEF_H_VIS  = 800;
    localparam int DEF_H_FP   = 56;
    localparam int DEF_H_SYNC = 120;
    localparam int DEF_H_BP   = 64;
    localparam int DEF_V_VIS  = 600;
    localparam int DEF_V_FP   = 37;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 23;

    typedef enum logic [0:0] {
        FLIP_IDLE    = 1'b0,
        FLIP_PENDING = 1'b1
    } flip_state_t;

    function automatic int line_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic logic in_window(input logic [10:0] cnt, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_scheduler_toggle_sync.sv
// +---------------------------------------------------------------------------+
// | vga_timing_scheduler_toggle_sync : 2-FF toggle synchroniser, edge pulse    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module vga_timing_scheduler_toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic toggle_i,
    output logic pulse_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], toggle_i};
        end
    end

    // Stages 0..1 resolve metastability; stage 2 only delays for edge detection.
    assign pulse_o = sync_q[1] ^ sync_q[2];

endmodule

`default_nettype wire

// File: rtl/vga_timing_scheduler.sv
// +---------------------------------------------------------------------------+
// | vga_timing_scheduler : VGA raster timing plus frame-aligned page flips     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module vga_timing_scheduler
    import vga_timing_scheduler_pkg::*;
#(
    parameter int          H_VIS      = DEF_H_VIS,
    parameter int          H_FP       = DEF_H_FP,
    parameter int          H_SYNC     = DEF_H_SYNC,
    parameter int          H_BP       = DEF_H_BP,
    parameter int          V_VIS      = DEF_V_VIS,
    parameter int          V_FP       = DEF_V_FP,
    parameter int          V_SYNC     = DEF_V_SYNC,
    parameter int          V_BP       = DEF_V_BP,
    parameter logic        SYNC_POL   = 1'b1,
    parameter logic [31:0] RESET_BASE = 32'h0000_0000
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        flip_toggle,
    input  logic [31:0] back_base_address,
    output logic [31:0] monitor_base_address,
    output logic        flip_done,
    output logic        flip_pending,
    output logic        hsync,
    output logic        vsync,
    output logic        visible,
    output logic        line,
    output logic        frame,
    output logic [19:0] pixel
);

    localparam int          H_TOTAL    = line_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int          V_TOTAL    = line_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam logic [10:0] HC_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] VC_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] HC_VIS     = 11'(H_VIS);
    localparam logic [10:0] VC_VIS     = 11'(V_VIS);
    localparam logic [10:0] HC_SYNC_LO = 11'(H_VIS + H_FP);
    localparam logic [10:0] HC_SYNC_HI = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VC_SYNC_LO = 11'(V_VIS + V_FP);
    localparam logic [10:0] VC_SYNC_HI = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [19:0] PIX_LAST   = 20'(H_VIS * V_VIS - 1);

    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        visible_q, line_q, frame_q, hsync_q, vsync_q;
    logic [19:0] pixel_q, pixel_d;
    flip_state_t state_q, state_d;
    logic [31:0] next_base_q, next_base_d, base_q, base_d;
    logic        flip_done_q, flip_done_d;
    logic        flip_req, visible_hit, frame_hit, first_cell;

    vga_timing_scheduler_toggle_sync u_flip_sync (
        .clk      (vga_clk),
        .rst      (rst),
        .toggle_i (flip_toggle),
        .pulse_o  (flip_req)
    );

    always_comb begin
        hcnt_d = hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == HC_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VC_LAST) ? 11'd0 : vcnt_q + 11'd1;
        end
    end

    assign visible_hit = (hcnt_q < HC_VIS) && (vcnt_q < VC_VIS);
    assign frame_hit   = (hcnt_q == 11'd0) && (vcnt_q == VC_VIS);
    assign first_cell  = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);

    // The first visible cell keeps the 0 left by the frame clear; later cells count up.
    always_comb begin
        pixel_d = pixel_q;
        if (frame_hit) begin
            pixel_d = '0;
        end else if (visible_hit && !first_cell && (pixel_q != PIX_LAST)) begin
            pixel_d = pixel_q + 20'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_base_d = next_base_q;
        base_d      = base_q;
        flip_done_d = 1'b0;
        case (state_q)
            FLIP_IDLE: begin
                if (flip_req) begin
                    next_base_d = back_base_address;
                    state_d     = FLIP_PENDING;
                end
            end
            FLIP_PENDING: begin
                if (flip_req) begin
                    next_base_d = back_base_address;
                end
                if (frame_hit) begin
                    base_d      = next_base_d;
                    flip_done_d = 1'b1;
                    state_d     = FLIP_IDLE;
                end
            end
            default: state_d = FLIP_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            visible_q   <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            pixel_q     <= '0;
            state_q     <= FLIP_IDLE;
            next_base_q <= RESET_BASE;
            base_q      <= RESET_BASE;
            flip_done_q <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            visible_q   <= visible_hit;
            line_q      <= (hcnt_q == HC_VIS);
            frame_q     <= frame_hit;
            hsync_q     <= in_window(hcnt_q, HC_SYNC_LO, HC_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
            vsync_q     <= in_window(vcnt_q, VC_SYNC_LO, VC_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
            pixel_q     <= pixel_d;
            state_q     <= state_d;
            next_base_q <= next_base_d;
            base_q      <= base_d;
            flip_done_q <= flip_done_d;
        end
    end

    assign monitor_base_address = base_q;
    assign flip_done            = flip_done_q;
    assign flip_pending         = (state_q == FLIP_PENDING);
    assign hsync                = hsync_q;
    assign vsync                = vsync_q;
    assign visible              = visible_q;
    assign line                 = line_q;
    assign frame                = frame_q;
    assign pixel                = pixel_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_scheduler.sv
// +---------------------------------------------------------------------------+
// | tb_vga_timing_scheduler : reduced-raster bench with a position-based model |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_vga_timing_scheduler;

    localparam int          HV  = 16, HF = 3, HS = 4, HB = 5;
    localparam int          VV  = 10, VF = 2, VS = 2, VB = 3;
    localparam int          HT  = HV + HF + HS + HB;
    localparam int          VT  = VV + VF + VS + VB;
    localparam int          FR  = HT * VT;
    localparam logic        POL = 1'b1;
    localparam logic [31:0] RB  = 32'hDEAD_0000;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        flip_toggle;
    logic [31:0] back_base_address;
    logic [31:0] monitor_base_address;
    logic        flip_done, flip_pending, hsync, vsync, visible, line, frame;
    logic [19:0] pixel;

    int total = 0;
    int bad   = 0;

    vga_timing_scheduler #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .RESET_BASE(RB)
    ) dut (
        .vga_clk              (vga_clk),
        .rst                  (rst),
        .flip_toggle          (flip_toggle),
        .back_base_address    (back_base_address),
        .monitor_base_address (monitor_base_address),
        .flip_done            (flip_done),
        .flip_pending         (flip_pending),
        .hsync                (hsync),
        .vsync                (vsync),
        .visible              (visible),
        .line                 (line),
        .frame                (frame),
        .pixel                (pixel)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k counts clock edges since reset release; output after edge k shows raster
    // position k mod FR. Flip requests appear three edges after a toggle change.
    int          k = -1;
    logic [31:0] m_base, m_nb;
    logic        m_pend, m_done;
    logic        t1, t2, t3;

    always @(posedge vga_clk) begin
        logic req, fr;
        if (rst) begin
            k = -1;
            m_base = RB; m_nb = RB; m_pend = 1'b0; m_done = 1'b0;
            t1 = 1'b0; t2 = 1'b0; t3 = 1'b0;
        end else begin
            k   = k + 1;
            req = (t2 != t3);
            t3 = t2; t2 = t1; t1 = flip_toggle;
            fr  = ((k % FR) == VV * HT);
            m_done = 1'b0;
            if (req) m_nb = back_base_address;
            if (m_pend && fr) begin
                m_base = m_nb; m_done = 1'b1; m_pend = 1'b0;
            end else if (req) begin
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge vga_clk) begin
        int pos, h, v, e_pix;
        logic e_vis, e_line, e_frame, e_hs, e_vs;
        if (rst || k < 0) begin
            e_vis = 0; e_line = 0; e_frame = 0; e_hs = ~POL; e_vs = ~POL; e_pix = 0;
            check("rst_base", monitor_base_address, RB);
            check("rst_pending", {31'd0, flip_pending}, 32'd0);
            check("rst_done", {31'd0, flip_done}, 32'd0);
        end else begin
            pos     = k % FR;
            h       = pos % HT;
            v       = pos / HT;
            e_vis   = (h < HV) && (v < VV);
            e_line  = (h == HV);
            e_frame = (h == 0) && (v == VV);
            e_hs    = (h >= HV + HF && h < HV + HF + HS) ? POL : ~POL;
            e_vs    = (v >= VV + VF && v < VV + VF + VS) ? POL : ~POL;
            e_pix   = (v < VV) ? v * HV + ((h < HV) ? h : HV - 1) : 0;
            check("base", monitor_base_address, m_base);
            check("pending", {31'd0, flip_pending}, {31'd0, m_pend});
            check("done", {31'd0, flip_done}, {31'd0, m_done});
        end
        check("visible", {31'd0, visible}, {31'd0, e_vis});
        check("line", {31'd0, line}, {31'd0, e_line});
        check("frame", {31'd0, frame}, {31'd0, e_frame});
        check("hsync", {31'd0, hsync}, {31'd0, e_hs});
        check("vsync", {31'd0, vsync}, {31'd0, e_vs});
        check("pixel", {12'd0, pixel}, 32'(e_pix));
    end

    task automatic step();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic drive_after_edge();
        @(posedge vga_clk);
        #1;
    endtask

    // Runs until the frame pulse is seen; n = edges waited, dones = flip_done pulses seen.
    task automatic wait_frame(output int n, output int dones);
        logic seen;
        seen = 1'b0; n = 0; dones = 0;
        while (!seen && n < 2000) begin
            step();
            n++;
            seen = frame;
            if (flip_done) dones++;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wait_frame: no frame pulse within %0d cycles", n);
        end
    endtask

    // Leaves the bench #1 after the edge at raster position FR-relative 'p'.
    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        drive_after_edge();
        while (((k % FR) != p) && guard < 2000) begin
            drive_after_edge();
            guard++;
        end
        if (guard >= 2000) begin
            total++; bad++;
            $display("FAIL wait_pos: position %0d not reached", p);
        end
    endtask

    initial begin
        int n, dones, vis_n, hs_n, vs_n, line_n, frame_n, first_line, second_line;
        logic [19:0] pix_max;

        rst = 1'b1; flip_toggle = 1'b0; back_base_address = 32'h0;
        repeat (5) @(posedge vga_clk);
        #1 rst = 1'b0;

        wait_frame(n, dones);
        check("first_frame_latency", n, 32'd281);

        vis_n = 0; hs_n = 0; vs_n = 0; line_n = 0; frame_n = 0; pix_max = '0;
        first_line = -1; second_line = -1;
        for (int i = 1; i <= FR; i++) begin
            step();
            if (visible) vis_n++;
            if (hsync == POL) hs_n++;
            if (vsync == POL) vs_n++;
            if (frame) frame_n++;
            if (line) begin
                line_n++;
                if (first_line < 0) first_line = i;
                else if (second_line < 0) second_line = i;
            end
            if (pixel > pix_max) pix_max = pixel;
            if (i == FR) check("frame_period", {31'd0, frame}, 32'd1);
        end
        check("visible_count", vis_n, 32'd160);
        check("hsync_count", hs_n, 32'd68);
        check("vsync_count", vs_n, 32'd56);
        check("line_count", line_n, 32'd17);
        check("frame_count", frame_n, 32'd1);
        check("line_period", 32'(second_line - first_line), 32'd28);
        check("pixel_max", {12'd0, pix_max}, 32'd159);
        check("pixel_after_frame", {12'd0, pixel}, 32'd0);

        // Single flip, requested mid-frame
        repeat (300) drive_after_edge();
        back_base_address = 32'h0010_0000;
        flip_toggle = ~flip_toggle;
        step(); step();
        check("pending_early", {31'd0, flip_pending}, 32'd0);
        step();
        check("pending_3cyc", {31'd0, flip_pending}, 32'd1);
        wait_frame(n, dones);
        check("flip1_done", {31'd0, flip_done}, 32'd1);
        check("flip1_base", monitor_base_address, 32'h0010_0000);
        check("flip1_pending", {31'd0, flip_pending}, 32'd0);
        step();
        check("flip1_done_pulse", {31'd0, flip_done}, 32'd0);

        // Two requests in one frame: latest wins, one flip_done
        repeat (20) drive_after_edge();
        back_base_address = 32'h0000_1000;
        flip_toggle = ~flip_toggle;
        repeat (10) drive_after_edge();
        back_base_address = 32'h0000_2000;
        flip_toggle = ~flip_toggle;
        wait_frame(n, dones);
        step();
        if (flip_done) dones++;
        check("flip2_done_count", dones, 32'd1);
        check("flip2_base", monitor_base_address, 32'h0000_2000);

        // Request landing on the frame cycle while idle: deferred one frame
        back_base_address = 32'h0000_3000;
        wait_pos(VV * HT - 3);
        flip_toggle = ~flip_toggle;
        wait_frame(n, dones);
        check("coinc_idle_done", {31'd0, flip_done}, 32'd0);
        check("coinc_idle_base", monitor_base_address, 32'h0000_2000);
        check("coinc_idle_pending", {31'd0, flip_pending}, 32'd1);
        wait_frame(n, dones);
        check("coinc_next_done", {31'd0, flip_done}, 32'd1);
        check("coinc_next_base", monitor_base_address, 32'h0000_3000);

        // Request landing on the frame cycle while pending: new base applied now
        repeat (50) drive_after_edge();
        back_base_address = 32'h0000_4000;
        flip_toggle = ~flip_toggle;
        repeat (10) drive_after_edge();
        back_base_address = 32'h0000_5000;
        wait_pos(VV * HT - 3);
        flip_toggle = ~flip_toggle;
        wait_frame(n, dones);
        check("coinc_pend_done", {31'd0, flip_done}, 32'd1);
        check("coinc_pend_base", monitor_base_address, 32'h0000_5000);
        check("coinc_pend_pending", {31'd0, flip_pending}, 32'd0);

        // Mid-frame reset for 10 cycles
        repeat (150) drive_after_edge();
        rst = 1'b1;
        repeat (10) step();
        check("midrst_base", monitor_base_address, RB);
        check("midrst_pixel", {12'd0, pixel}, 32'd0);
        drive_after_edge();
        rst = 1'b0;
        wait_frame(n, dones);
        check("post_rst_frame_latency", n, 32'd281);
        check("post_rst_dones", dones, 32'd0);
        check("post_rst_base", monitor_base_address, RB);

        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
